// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// width codes and byte-strobe patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data/strobe placement, load
// extract/extend, and the funct3 legality plus alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wlanes,
  output logic [31:0] ldata,
  output logic        misaligned
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] wl;
  logic [NUM_LANES-1:0][7:0] rl;
  logic [7:0]                rb;
  logic [15:0]               rh;

  assign rl     = rword;
  assign wlanes = wl;

  // Narrow stores replicate across every lane so the strobe alone picks the target.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wl[i] = (funct3 == F3_B) ? wdata[7:0] :
                   (funct3 == F3_H) ? wdata[8*(i%2) +: 8] :
                                      wdata[8*i +: 8];
  end

  assign rb = rl[off];
  assign rh = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    misaligned = 1'b0;
    ldata      = 32'd0;
    wstrb      = STRB_NONE;
    case (funct3)
      F3_B: begin
        ldata = {{24{rb[7]}}, rb};
        wstrb = STRB_B << off;
      end
      F3_H: begin
        misaligned = off[0];
        ldata      = {{16{rh[15]}}, rh};
        wstrb      = STRB_H << off;
      end
      F3_W: begin
        misaligned = |off;
        ldata      = rword;
        wstrb      = STRB_W;
      end
      F3_BU: begin
        misaligned = is_store;
        ldata      = {24'd0, rb};
      end
      F3_HU: begin
        misaligned = is_store | off[0];
        ldata      = {16'd0, rh};
      end
      default: misaligned = 1'b1;
    endcase
    if (!is_store) wstrb = STRB_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load or store per start on a req/ack bus.
// Define LSU_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT_CYCLES with err_bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err_misaligned,
  output logic              err_bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  lsu_state_e  state;
  logic        lat_store;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;

  logic        use_live;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wlanes;
  logic [31:0] al_ldata;
  logic        al_bad;

  // Aligner sees the live request in IDLE and the latched one afterwards.
  assign use_live = (state == ST_IDLE);
  assign al_store = use_live ? is_store   : lat_store;
  assign al_f3    = use_live ? funct3     : lat_f3;
  assign al_off   = use_live ? addr[1:0]  : lat_off;

  lsu_align u_align (
    .is_store   (al_store),
    .funct3     (al_f3),
    .off        (al_off),
    .wdata      (wdata),
    .rword      (mem_rdata),
    .wstrb      (al_wstrb),
    .wlanes     (al_wlanes),
    .ldata      (al_ldata),
    .misaligned (al_bad)
  );

  assign done = (state == ST_RESP);
  assign busy = !rst && (((state == ST_IDLE) && start) || (state == ST_WAIT));

`ifdef LSU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign err_bus = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      lat_store      <= 1'b0;
      lat_f3         <= 3'd0;
      lat_off        <= 2'd0;
      rdata          <= 32'd0;
      err_misaligned <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wstrb      <= 4'd0;
      mem_wdata      <= 32'd0;
`ifdef LSU_TIMEOUT_EN
      err_bus        <= 1'b0;
      to_cnt         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          lat_store      <= is_store;
          lat_f3         <= funct3;
          lat_off        <= addr[1:0];
          rdata          <= 32'd0;
          err_misaligned <= al_bad;
`ifdef LSU_TIMEOUT_EN
          err_bus        <= 1'b0;
          to_cnt         <= '0;
`endif
          if (al_bad) begin
            state <= ST_RESP;
          end else begin
            state     <= ST_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wstrb <= al_wstrb;
            mem_wdata <= al_wlanes;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= lat_store ? 32'd0 : al_ldata;
            state   <= ST_RESP;
          end
`ifdef LSU_TIMEOUT_EN
          // An ack in the timeout cycle takes priority over the abort.
          else if (to_hit) begin
            mem_req <= 1'b0;
            err_bus <= 1'b1;
            state   <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int ADDR_W = 32;
  localparam int TO     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err_misaligned, err_bus;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err_misaligned(err_misaligned), .err_bus(err_bus), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        busy_start, req_at_start, we, stable, done_seen, busy_resp;
    logic        em, eb, done_twice, req_after;
    logic [31:0] a, wd, rd, rd_hold;
    logic [3:0]  strb;
    int          waits;
  } obs_t;

  // Drives one access and records what the DUT shows; tests judge the record.
  task automatic run_access(input bit st, input bit [2:0] f3, input bit [31:0] ad,
                            input bit [31:0] wd, input bit [31:0] bus_word,
                            input int ack_lat, input bit poke, output obs_t o);
    int n;
    o = '{default: 0};
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = ad; wdata = wd;
    #1 o.busy_start = busy;
    @(posedge clk); #1;
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    o.req_at_start = mem_req; o.a = mem_addr; o.strb = mem_wstrb; o.wd = mem_wdata; o.we = mem_we;
    o.stable = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      if ({mem_req, mem_addr, mem_wstrb, mem_wdata, mem_we} !== {1'b1, o.a, o.strb, o.wd, o.we})
        o.stable = 1'b0;
      mem_ack   = (n == ack_lat);
      mem_rdata = (n == ack_lat) ? bus_word : $urandom;
      if (poke) begin
        start = 1'b1; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; start = 1'b0; n++;
    end
    o.waits = n; o.done_seen = done; o.busy_resp = busy;
    o.rd = rdata; o.em = err_misaligned; o.eb = err_bus;
    if (poke) begin
      start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h40; wdata = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    o.done_twice = done; o.req_after = mem_req; o.rd_hold = rdata;
  endtask

  // Reference: legality, lane placement and extension from plain arithmetic.
  function automatic void model(input bit st, input bit [2:0] f3, input bit [31:0] ad,
                                input bit [31:0] wd, input bit [31:0] bw, output bit ok,
                                output bit [3:0] strb, output bit [31:0] lanes, output bit [31:0] rd);
    int sz, off;
    bit [31:0] v;
    off = int'(ad % 4);
    ok  = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = 1 << (f3 % 4);
    if (ok && (off % sz) != 0) ok = 1'b0;
    strb = 4'd0; lanes = 32'd0; rd = 32'd0;
    if (!ok) return;
    if (st) begin
      strb  = (sz == 4) ? 4'hF : 4'(((sz == 2) ? 3 : 1) << off);
      lanes = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    end else begin
      v = bw >> (8 * off);
      if (sz == 1) v = v & 32'hFF;
      else if (sz == 2) v = v & 32'hFFFF;
      if (f3 == 3'd0 && v[7])  v = v - 32'd256;
      if (f3 == 3'd1 && v[15]) v = v - 32'd65536;
      rd = v;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h100; wdata = 32'h1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({done, mem_req, mem_we, err_misaligned, err_bus} !== 5'd0) begin
      fails++; $display("FAIL reset_flags got %b want 00000", {done, mem_req, mem_we, err_misaligned, err_bus}); end
    checks++; if ({mem_addr, mem_wstrb, mem_wdata, rdata} !== 100'd0) begin
      fails++; $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wstrb, mem_wdata, rdata); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_store_word();
    obs_t o;
    run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0, o);
    checks++; if (o.busy_start !== 1'b1) begin fails++; $display("FAIL sw_busy_start got %b want 1", o.busy_start); end
    checks++; if ({o.req_at_start, o.we} !== 2'b11) begin fails++; $display("FAIL sw_req_we got %b want 11", {o.req_at_start, o.we}); end
    checks++; if (o.a !== 32'h100) begin fails++; $display("FAIL sw_addr got %h want 00000100", o.a); end
    checks++; if (o.strb !== 4'hF) begin fails++; $display("FAIL sw_strb got %b want 1111", o.strb); end
    checks++; if (o.wd !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata got %h want deadbeef", o.wd); end
    checks++; if (o.stable !== 1'b1 || o.waits !== 3) begin fails++; $display("FAIL sw_hold stable=%b waits=%0d want 1/3", o.stable, o.waits); end
    checks++; if ({o.done_seen, o.busy_resp, o.done_twice, o.req_after} !== 4'b1000) begin
      fails++; $display("FAIL sw_resp got %b want 1000", {o.done_seen, o.busy_resp, o.done_twice, o.req_after}); end
    checks++; if ({o.rd, o.em, o.eb} !== 34'd0) begin fails++; $display("FAIL sw_rdata got %h %b%b want 0", o.rd, o.em, o.eb); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF1234, 0, 1'b0, o);
    checks++; if (o.rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata got %h want ffffff80", o.rd); end
    checks++; if ({o.a, o.strb, o.we} !== {32'h200, 4'h0, 1'b0}) begin fails++; $display("FAIL lb_bus got %h %b %b want 200/0000/0", o.a, o.strb, o.we); end
    checks++; if (o.waits !== 1 || o.rd_hold !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_latency waits=%0d hold=%h want 1/ffffff80", o.waits, o.rd_hold); end
    run_access(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF1234, 1, 1'b0, o);
    checks++; if (o.rd !== 32'h00000080) begin fails++; $display("FAIL lbu_rdata got %h want 00000080", o.rd); end
  endtask

  task automatic test_store_half();
    obs_t o;
    run_access(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 1, 1'b0, o);
    checks++; if (o.a !== 32'h100) begin fails++; $display("FAIL sh_addr got %h want 00000100", o.a); end
    checks++; if (o.strb !== 4'b1100) begin fails++; $display("FAIL sh_strb got %b want 1100", o.strb); end
    checks++; if (o.wd !== 32'hABCDABCD) begin fails++; $display("FAIL sh_wdata got %h want abcdabcd", o.wd); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_access(1'b0, 3'd2, 32'h101, 32'h0, 32'h12345678, 0, 1'b0, o);
    checks++; if ({o.req_at_start, o.req_after} !== 2'b00 || o.waits !== 0) begin
      fails++; $display("FAIL lw_mis_bus req=%b%b waits=%0d want 00/0", o.req_at_start, o.req_after, o.waits); end
    checks++; if ({o.done_seen, o.em, o.eb, o.done_twice} !== 4'b1100 || o.rd !== 32'd0) begin
      fails++; $display("FAIL lw_mis_resp got %b rd=%h want 1100/0", {o.done_seen, o.em, o.eb, o.done_twice}, o.rd); end
    run_access(1'b1, 3'd4, 32'h100, 32'h5, 32'h0, 0, 1'b0, o);
    checks++; if (o.em !== 1'b1 || o.req_at_start !== 1'b0) begin fails++; $display("FAIL illegal_f3 em=%b req=%b want 1/0", o.em, o.req_at_start); end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    bit   seen_done;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd0; addr = 32'h203;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rstw_pre got mem_req=%b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_req, busy, done} !== 3'b000) begin fails++; $display("FAIL rstw_async got %b want 000", {mem_req, busy, done}); end
    seen_done = 1'b0;
    repeat (2) begin @(posedge clk); #1 seen_done |= done; end
    @(negedge clk) rst = 1'b0;
    mem_ack = 1'b1;
    repeat (2) begin @(posedge clk); #1 seen_done |= done; end
    mem_ack = 1'b0;
    checks++; if ({seen_done, mem_req, busy} !== 3'b000) begin fails++; $display("FAIL rstw_idle got %b want 000", {seen_done, mem_req, busy}); end
    run_access(1'b0, 3'd5, 32'h2, 32'h0, 32'hF00D0000, 0, 1'b0, o);
    checks++; if (o.rd !== 32'h0000F00D || o.em !== 1'b0) begin fails++; $display("FAIL rstw_lhu got %h em=%b want 0000f00d/0", o.rd, o.em); end
  endtask

  task automatic test_random();
    obs_t o;
    bit st, ok;
    bit [2:0] f3;
    bit [31:0] ad, wd, bw, e_lanes, e_rd;
    bit [3:0] e_strb;
    int lat;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom); f3 = 3'($urandom); ad = $urandom; wd = $urandom; bw = $urandom;
      lat = $urandom_range(0, 3);
      model(st, f3, ad, wd, bw, ok, e_strb, e_lanes, e_rd);
      run_access(st, f3, ad, wd, bw, lat, 1'($urandom), o);
      checks++; if ({o.done_seen, o.em, o.eb, o.done_twice, o.req_after} !== {1'b1, !ok, 3'b000}) begin
        fails++; $display("FAIL rnd%0d_flags got %b want %b", i, {o.done_seen, o.em, o.eb, o.done_twice, o.req_after}, {1'b1, !ok, 3'b000}); end
      checks++; if (o.rd !== e_rd || o.rd_hold !== e_rd) begin fails++; $display("FAIL rnd%0d_rdata got %h/%h want %h", i, o.rd, o.rd_hold, e_rd); end
      if (ok) begin
        checks++; if ({o.a, o.strb, o.we, o.stable} !== {ad[31:2], 2'b00, e_strb, st, 1'b1} || o.waits !== lat + 1) begin
          fails++; $display("FAIL rnd%0d_bus got %h %b %b %b w%0d want %h %b %b 1 w%0d", i, o.a, o.strb, o.we, o.stable, o.waits, {ad[31:2], 2'b00}, e_strb, st, lat + 1); end
        if (st) begin
          checks++; if (o.wd !== e_lanes) begin fails++; $display("FAIL rnd%0d_wdata got %h want %h", i, o.wd, e_lanes); end
        end
      end else begin
        checks++; if (o.req_at_start !== 1'b0 || o.waits !== 0) begin fails++; $display("FAIL rnd%0d_noreq req=%b waits=%0d want 0/0", i, o.req_at_start, o.waits); end
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h0, -1, 1'b1, o);
    checks++; if ({o.done_seen, o.eb, o.em} !== 3'b110 || o.waits !== TO) begin
      fails++; $display("FAIL timeout got %b waits=%0d want 110/%0d", {o.done_seen, o.eb, o.em}, o.waits, TO); end
    checks++; if (o.rd !== 32'd0 || o.req_after !== 1'b0) begin fails++; $display("FAIL timeout_rd got %h req=%b want 0/0", o.rd, o.req_after); end
    run_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h13579BDF, TO - 1, 1'b0, o);
    checks++; if (o.eb !== 1'b0 || o.rd !== 32'h13579BDF) begin fails++; $display("FAIL timeout_ack_wins eb=%b rd=%h want 0/13579bdf", o.eb, o.rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_reset_in_wait();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
